accumulator_nbit: RTL
=====================

# accumulator_nbit

Handshaked running-sum stage that sits directly in front of the team's `adder_nbit` ripple adder. It owns the accumulator register and feeds the adder with the register value and the incoming operand. It folds exactly `NUM_SAMPLES` operands into one modulo-2^`BIT_WIDTH` sum with a sticky overflow flag, then presents the result to a downstream consumer under a valid/ack handshake.

## Interface
- `BIT_WIDTH`, default 4: operand, accumulator and result width.
- `NUM_SAMPLES`, default 8: operands per result; legal range ≥1.
- `clk`  in  1: single clock, rising edge.
- `n_rst`  in  1: asynchronous, active-low reset.
- `clear`  in  1: synchronous abort; returns the block to IDLE.
- `data_in`  in  `BIT_WIDTH`: operand.
- `data_valid`  in  1: `data_in` is valid this cycle.
- `data_ready`  out  1: block accepts an operand this cycle.
- `sum_out`  out  `BIT_WIDTH`: accumulator register, driven directly.
- `overflow_flag`  out  1: sticky; set if any addition of the current run produced a carry-out.
- `result_valid`  out  1: `sum_out`/`overflow_flag` are a final result.
- `result_ack`  in  1: consumer takes the result.

## Operation
- A transfer is `data_valid & data_ready` sampled at a rising `clk`.
- The adder is combinational with `a = acc`, `b = data_in`, and `carry_in = 0`. Its `sum` and `overflow` (carry-out) are consumed only on a transfer.
- Registers: `state`, `acc[BIT_WIDTH-1:0]`, `count` (width `$clog2(NUM_SAMPLES+1)`), `ovf`.
- Reset (`n_rst`=0, asynchronous):
  - Register values: `state`=IDLE, `acc`=0, `count`=0, `ovf`=0.
  - Resulting outputs: `sum_out`=0, `overflow_flag`=0, `result_valid`=0, `data_ready`=1.
- States:
  - **IDLE**: `data_ready`=1.
    - On transfer: `acc`←adder sum (equals `data_in`); `count`←1; `ovf`←carry (0).
    - Next state is ACCUM, or DONE if `NUM_SAMPLES`=1.
  - **ACCUM**: `data_ready`=1.
    - On transfer: `acc`←sum; `ovf`←`ovf` | carry; `count`←`count`+1.
    - Goes to DONE on the transfer that makes `count` = `NUM_SAMPLES`.
    - Without a transfer, all registers hold; gaps in `data_valid` are allowed.
  - **DONE**: `data_ready`=0 and `result_valid`=1; `acc`/`ovf` hold.
    - On `result_ack`=1: go to IDLE with `acc`=0, `count`=0, `ovf`=0.
- `data_ready` and `result_valid` are pure decodes of `state`, with no input-to-output combinational path.
- Arithmetic: `acc` wraps modulo 2^`BIT_WIDTH`. No saturation.
- `clear`=1 has top priority in every state:
  - Next state is IDLE with `acc`, `count` and `ovf` zeroed.
  - A transfer in the same cycle is discarded.
  - A `result_ack` in the same cycle is irrelevant.
- `result_ack` outside DONE is ignored.
- `data_valid` in DONE is ignored and no data is consumed.
- Reset asserted mid-run immediately forces the reset values. The partial sum is lost.

## Timing
- One transfer per cycle is sustained; there are no bubbles in IDLE/ACCUM.
- `sum_out` reflects a transfer one cycle after its clock edge.
- `result_valid` rises in the cycle after the `NUM_SAMPLES`-th transfer edge.
- Minimum run length is `NUM_SAMPLES` transfer cycles plus 1 DONE cycle, when `result_ack` is already high.
- After an ack, `data_ready`=1 in the very next cycle and `sum_out`=0.
- The adder is a single-cycle combinational path: `acc` → ripple chain → `acc` D input. `BIT_WIDTH` is bounded by timing closure, not by logic.

## Structure
- Shared package `accum_pkg`:
  - `typedef enum logic [1:0] {IDLE, ACCUM, DONE} accum_state_t`.
  - No other shared constants.
- One sub-module: the existing `adder_nbit #(.BIT_WIDTH(BIT_WIDTH))`, instantiated once. All carry handling uses its `overflow` port; there is no behavioural `+` on `acc`.
- Control (next-state/output decode) and the datapath registers live in this module.

## Test plan
All scenarios use `BIT_WIDTH`=4 and `NUM_SAMPLES`=4.
- **Reset**: release `n_rst` → `sum_out`=0, `overflow_flag`=0, `result_valid`=0, `data_ready`=1.
- **Basic run**: back-to-back transfers 1,2,3,4 → `result_valid` high the cycle after the 4th edge, `sum_out`=10, `overflow_flag`=0. Then `result_ack` → next cycle `data_ready`=1, `sum_out`=0.
- **Wrap and sticky flag**: transfers 8,8,1,1 → `sum_out`=2, `overflow_flag`=1. The flag is set after the 2nd transfer and stays set.
- **Backpressure and gaps**:
  - Stimulus: `data_valid` toggling 1,0,1,0,… with values 3,3,3,3; `result_ack` held 0 for 5 cycles in DONE.
  - Response: `sum_out`=12 held stable, `data_ready`=0 throughout DONE, extra `data_valid` pulses ignored.
- **Clear collision**: after transfers 5,5, assert `clear` with `data_valid`=1 and `data_in`=7 in the same cycle → next cycle IDLE, `sum_out`=0, `overflow_flag`=0. A subsequent 1,1,1,1 run gives 4.
- **Async reset mid-run**: after 2 transfers, pulse `n_rst` low between clock edges → outputs reach reset values without waiting for a clock edge. The next full run 2,2,2,2 gives 8.

Source files
------------

// File: rtl/accum_pkg.sv
// Shared types for the running-sum stage.
// Holds the control state encoding.
package accum_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ACCUM,
      DONE
   } accum_state_t;

endpackage

// File: rtl/adder_nbit.sv
// Ripple-carry adder, BIT_WIDTH bits.
// Carry-out of the MSB is reported as overflow.
module adder_nbit #(
   parameter int BIT_WIDTH = 4
) (
   input  logic [BIT_WIDTH-1:0] a,
   input  logic [BIT_WIDTH-1:0] b,
   input  logic                 carry_in,
   output logic [BIT_WIDTH-1:0] sum,
   output logic                 overflow
);

   logic [BIT_WIDTH:0] carry;

   assign carry[0] = carry_in;

   // One full adder per bit, chained through carry
   for (genvar i = 0; i < BIT_WIDTH; i++) begin : g_fa
      assign sum[i]     = a[i] ^ b[i] ^ carry[i];
      assign carry[i+1] = (a[i] & b[i])
                        | (carry[i] & (a[i] ^ b[i]));
   end

   assign overflow = carry[BIT_WIDTH];

endmodule

// File: rtl/accumulator_nbit.sv
// Handshaked running-sum stage in front of adder_nbit.
// Folds NUM_SAMPLES operands, then holds the result until acked.
module accumulator_nbit
   import accum_pkg::*;
#(
   parameter int BIT_WIDTH   = 4,
   parameter int NUM_SAMPLES = 8
) (
   input  logic                 clk,
   input  logic                 n_rst,
   input  logic                 clear,
   input  logic [BIT_WIDTH-1:0] data_in,
   input  logic                 data_valid,
   output logic                 data_ready,
   output logic [BIT_WIDTH-1:0] sum_out,
   output logic                 overflow_flag,
   output logic                 result_valid,
   input  logic                 result_ack
);

   localparam int CW = $clog2(NUM_SAMPLES + 1);
   localparam logic [CW-1:0] LAST = CW'(NUM_SAMPLES);

   accum_state_t         state_q, state_d;
   logic [BIT_WIDTH-1:0] acc_q, acc_d;
   logic [CW-1:0]        count_q, count_d;
   logic                 ovf_q, ovf_d;

   logic [BIT_WIDTH-1:0] add_sum;
   logic                 add_cout;
   logic [CW-1:0]        count_inc;
   logic                 xfer;

   adder_nbit #(
      .BIT_WIDTH(BIT_WIDTH)
   ) u_adder (
      .a        (acc_q),
      .b        (data_in),
      .carry_in (1'b0),
      .sum      (add_sum),
      .overflow (add_cout)
   );

   assign data_ready    = (state_q != DONE);
   assign result_valid  = (state_q == DONE);
   assign sum_out       = acc_q;
   assign overflow_flag = ovf_q;

   assign xfer      = data_valid & data_ready;
   assign count_inc = count_q + CW'(1);

   // Next-state and datapath update; clear overrides everything
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      count_d = count_q;
      ovf_d   = ovf_q;
      if (clear) begin
         state_d = IDLE;
         acc_d   = '0;
         count_d = '0;
         ovf_d   = 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (xfer) begin
                  acc_d   = add_sum;
                  ovf_d   = add_cout;
                  count_d = CW'(1);
                  state_d = (NUM_SAMPLES == 1) ? DONE : ACCUM;
               end
            end
            ACCUM: begin
               if (xfer) begin
                  acc_d   = add_sum;
                  ovf_d   = ovf_q | add_cout;
                  count_d = count_inc;
                  if (count_inc == LAST) begin
                     state_d = DONE;
                  end
               end
            end
            DONE: begin
               if (result_ack) begin
                  state_d = IDLE;
                  acc_d   = '0;
                  count_d = '0;
                  ovf_d   = 1'b0;
               end
            end
            default: begin
               state_d = IDLE;
               acc_d   = '0;
               count_d = '0;
               ovf_d   = 1'b0;
            end
         endcase
      end
   end

   // State and datapath registers, async active-low reset
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q <= IDLE;
         acc_q   <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
      end
   end

endmodule
